// File: rtl/mdio_mmd_target_if.sv
// MDIO management target bus bundle.
// Groups the serial MDIO lines and the register-file side strobes/data so the
// target and its environment share one connection.
//   master : station manager / register file side (drives MDIO_OUT, MDIO_OE, RD_DATA)
//   slave  : the MDIO target (drives serial read data, address, write data, strobes)
interface mdio_mmd_target_if;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        MDIO_IN;
  logic        MDIO_IN_OE;
  logic [15:0] ADDR;
  logic [4:0]  DEV_ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_STB;
  logic        MDIO_DONE;
  logic        ERR;

  modport master (
    output MDIO_OUT, MDIO_OE, RD_DATA,
    input  MDIO_IN, MDIO_IN_OE, ADDR, DEV_ADDR, WR_DATA,
    input  WR_STB, RD_STB, MDIO_DONE, ERR
  );

  modport slave (
    input  MDIO_OUT, MDIO_OE, RD_DATA,
    output MDIO_IN, MDIO_IN_OE, ADDR, DEV_ADDR, WR_DATA,
    output WR_STB, RD_STB, MDIO_DONE, ERR
  );
endinterface

// File: rtl/mdio_mmd_target.sv
// MDIO (Clause 22 / Clause 45) management target.
// Hunts for a preamble, decodes the frame header, then either shifts in write
// or address data, serves read data back on MDIO_IN, or skips a frame meant
// for somebody else.
// Ports:
//   MDC   : management clock, all logic on its rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of mdio_mmd_target_if (serial lines, address, data, strobes)
// Parameters:
//   PHY_ADDR   : PHY address answered
//   PRE_LEN    : preamble 1s required before ST (0 = preamble suppression)
//   ENABLE_C45 : decode Clause 45 frames when 1
module mdio_mmd_target #(
  parameter logic [4:0] PHY_ADDR   = 5'h00,
  parameter int         PRE_LEN    = 32,
  parameter bit         ENABLE_C45 = 1'b1
) (
  input  logic             MDC,
  input  logic             reset,
  mdio_mmd_target_if.slave bus
);

  localparam int            PW      = (PRE_LEN < 1) ? 1 : $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  typedef enum logic [2:0] {HUNT, HDR, TA, WDATA, RDATA, SKIP} state_t;
  typedef enum logic [2:0] {K_C22W, K_C22R, K_C45A, K_C45W, K_C45R, K_C45RI} kind_t;

  state_t        state, state_n;
  kind_t         kind, kind_n;
  logic [PW-1:0] pre_cnt;
  logic [4:0]    bit_cnt;
  logic [11:0]   hdr_sh;
  logic [15:0]   data_sh;
  logic [15:0]   addr_reg;

  logic [12:0]   hdr_word;
  logic [15:0]   wr_word;
  logic          is_read, next_is_read;
  logic          hdr_accept, wr_done, rd_done, err_n;
  logic          drive_latch, drive_shift, drive_stop;

  // Header bits after ST[1]: {ST[0], OP[1:0], PHYAD[4:0], REGAD/DEVAD[4:0]}
  assign hdr_word = {hdr_sh, bus.MDIO_OUT};
  assign wr_word  = {data_sh[14:0], bus.MDIO_OUT};

  assign is_read      = (kind == K_C22R) || (kind == K_C45R) || (kind == K_C45RI);
  assign next_is_read = (kind_n == K_C22R) || (kind_n == K_C45R) || (kind_n == K_C45RI);

  always_ff @(posedge MDC or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_n;
  end

  // Next state plus one-cycle control decisions. ST[1] is always 0 here, so
  // only ST[0] is needed to tell Clause 22 from Clause 45.
  always_comb begin
    state_n     = state;
    kind_n      = kind;
    hdr_accept  = 1'b0;
    wr_done     = 1'b0;
    rd_done     = 1'b0;
    err_n       = 1'b0;
    drive_latch = 1'b0;
    drive_shift = 1'b0;
    drive_stop  = 1'b0;
    case (state)
      HUNT: begin
        if (bus.MDIO_OE && !bus.MDIO_OUT && (pre_cnt >= PRE_MAX)) state_n = HDR;
      end
      HDR: begin
        if (!bus.MDIO_OE) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (bit_cnt == 5'd12) begin
          hdr_accept = 1'b1;
          if (hdr_word[9:5] != PHY_ADDR) begin
            hdr_accept = 1'b0;
          end else if (hdr_word[12]) begin
            if (hdr_word[11:10] == 2'b01)      kind_n = K_C22W;
            else if (hdr_word[11:10] == 2'b10) kind_n = K_C22R;
            else                               hdr_accept = 1'b0;
          end else if (ENABLE_C45) begin
            case (hdr_word[11:10])
              2'b00:   kind_n = K_C45A;
              2'b01:   kind_n = K_C45W;
              2'b11:   kind_n = K_C45R;
              default: kind_n = K_C45RI;
            endcase
          end else begin
            hdr_accept = 1'b0;
          end
          state_n = hdr_accept ? TA : SKIP;
        end
      end
      TA: begin
        if (is_read) begin
          // TA1 of a read is not checked; TA2 must see the manager released
          if (bit_cnt == 5'd0) begin
            drive_latch = 1'b1;
          end else if (bus.MDIO_OE) begin
            err_n      = 1'b1;
            drive_stop = 1'b1;
            state_n    = HUNT;
          end else begin
            drive_shift = 1'b1;
            state_n     = RDATA;
          end
        end else if (!bus.MDIO_OE) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (bit_cnt == 5'd1) begin
          state_n = WDATA;
        end
      end
      WDATA: begin
        if (!bus.MDIO_OE) begin
          err_n   = 1'b1;
          state_n = HUNT;
        end else if (bit_cnt == 5'd15) begin
          wr_done = 1'b1;
          state_n = HUNT;
        end
      end
      RDATA: begin
        if (bus.MDIO_OE) begin
          err_n      = 1'b1;
          drive_stop = 1'b1;
          state_n    = HUNT;
        end else if (bit_cnt == 5'd15) begin
          rd_done    = 1'b1;
          drive_stop = 1'b1;
          state_n    = HUNT;
        end else begin
          drive_shift = 1'b1;
        end
      end
      SKIP: begin
        if (bit_cnt == 5'd17) state_n = HUNT;
      end
      default: state_n = HUNT;
    endcase
  end

  // Datapath and registered outputs. The preamble count only runs in HUNT,
  // so leaving HUNT for any reason restarts it from zero.
  always_ff @(posedge MDC or posedge reset) begin
    if (reset) begin
      pre_cnt        <= '0;
      bit_cnt        <= '0;
      kind           <= K_C22W;
      hdr_sh         <= '0;
      data_sh        <= '0;
      addr_reg       <= '0;
      bus.ADDR       <= '0;
      bus.DEV_ADDR   <= '0;
      bus.WR_DATA    <= '0;
      bus.MDIO_IN    <= 1'b0;
      bus.MDIO_IN_OE <= 1'b0;
      bus.WR_STB     <= 1'b0;
      bus.RD_STB     <= 1'b0;
      bus.MDIO_DONE  <= 1'b0;
      bus.ERR        <= 1'b0;
    end else begin
      bus.WR_STB    <= wr_done && (kind != K_C45A);
      bus.MDIO_DONE <= wr_done || rd_done;
      bus.ERR       <= err_n;
      bus.RD_STB    <= hdr_accept && next_is_read;
      kind          <= kind_n;
      bit_cnt       <= ((state_n != state) || (state == HUNT)) ? 5'd0 : bit_cnt + 5'd1;

      if ((state != HUNT) || (bus.MDIO_OE && !bus.MDIO_OUT)) pre_cnt <= '0;
      else if (bus.MDIO_OE && (pre_cnt < PRE_MAX))           pre_cnt <= pre_cnt + PW'(1);

      if (state == HDR) hdr_sh <= {hdr_sh[10:0], bus.MDIO_OUT};

      if (hdr_accept) begin
        if ((kind_n == K_C22W) || (kind_n == K_C22R)) begin
          bus.ADDR     <= {11'b0, hdr_word[4:0]};
          bus.DEV_ADDR <= 5'd0;
        end else begin
          bus.ADDR     <= addr_reg;
          bus.DEV_ADDR <= hdr_word[4:0];
        end
      end

      if (state == WDATA) data_sh <= wr_word;
      if (wr_done) begin
        if (kind == K_C45A) addr_reg    <= wr_word;
        else                bus.WR_DATA <= wr_word;
      end
      if (rd_done && (kind == K_C45RI)) addr_reg <= addr_reg + 16'd1;

      // Read data is latched one edge after RD_STB, then TA2 drives a 0
      if (drive_latch) begin
        data_sh        <= bus.RD_DATA;
        bus.MDIO_IN_OE <= 1'b1;
        bus.MDIO_IN    <= 1'b0;
      end else if (drive_shift) begin
        bus.MDIO_IN <= data_sh[15];
        data_sh     <= {data_sh[14:0], 1'b0};
      end else if (drive_stop) begin
        bus.MDIO_IN_OE <= 1'b0;
        bus.MDIO_IN    <= 1'b0;
      end
    end
  end

endmodule
